// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480@60 VGA raster timing from the system clock.
// Counts pixels/lines and registers sync, blanking and frame strobes.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high
//   hCount      horizontal position, 0..H_TOTAL-1
//   vCount      vertical position, 0..V_TOTAL-1
//   hSync       active-low horizontal sync
//   vSync       active-low vertical sync
//   bright      high inside the visible window
//   pix_en      strobe in the last clk of each pixel period
//   frame_start one-clk pulse at (0,0) after a frame wrap
module vga_sync_gen #(
  parameter int CLK_DIV     = 4,
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_VIS_START = 144,
  parameter int H_VIS       = 640,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int V_VIS_START = 35,
  parameter int V_VIS       = 480
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       hSync,
  output logic       vSync,
  output logic       bright,
  output logic       pix_en,
  output logic       frame_start
);

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SW     = 10'(H_SYNC);
  localparam logic [9:0] V_SW     = 10'(V_SYNC);
  localparam logic [9:0] H_VS     = 10'(H_VIS_START);
  localparam logic [9:0] H_VE     = 10'(H_VIS_START + H_VIS);
  localparam logic [9:0] V_VS     = 10'(V_VIS_START);
  localparam logic [9:0] V_VE     = 10'(V_VIS_START + V_VIS);

  logic [3:0] div;
  logic [3:0] div_n;
  logic [9:0] h_n;
  logic [9:0] v_n;
  logic       wrap;

  // With CLK_DIV=1 DIV_LAST is 0 and div never leaves 0,
  // so pix_en is constantly high.
  assign pix_en = (div == DIV_LAST);

  always_comb begin
    div_n = pix_en ? 4'd0 : div + 4'd1;
    h_n   = hCount;
    v_n   = vCount;
    wrap  = 1'b0;
    if (pix_en) begin
      if (hCount == H_LAST) begin
        h_n = 10'd0;
        if (vCount == V_LAST) begin
          v_n  = 10'd0;
          wrap = 1'b1;
        end else begin
          v_n = vCount + 10'd1;
        end
      end else begin
        h_n = hCount + 10'd1;
      end
    end
  end

  // Decoded outputs use next-state counters so they line up
  // with the counter values they are registered alongside.
  always_ff @(posedge clk) begin
    if (reset) begin
      div         <= 4'd0;
      hCount      <= 10'd0;
      vCount      <= 10'd0;
      hSync       <= 1'b0;
      vSync       <= 1'b0;
      bright      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div         <= div_n;
      hCount      <= h_n;
      vCount      <= v_n;
      hSync       <= (h_n >= H_SW);
      vSync       <= (v_n >= V_SW);
      bright      <= (h_n >= H_VS) && (h_n < H_VE) &&
                     (v_n >= V_VS) && (v_n < V_VE);
      frame_start <= wrap;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed checks of vga_sync_gen timing.
// Default, small-raster and CLK_DIV=1 builds run side by side.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  logic [9:0] h_a, v_a, h_b, v_b, h_c, v_c;
  logic hs_a, vs_a, br_a, pe_a, fs_a;
  logic hs_b, vs_b, br_b, pe_b, fs_b;
  logic hs_c, vs_c, br_c, pe_c, fs_c;

  vga_sync_gen dut_a (
    .clk(clk), .reset(reset),
    .hCount(h_a), .vCount(v_a),
    .hSync(hs_a), .vSync(vs_a),
    .bright(br_a), .pix_en(pe_a),
    .frame_start(fs_a)
  );

  // Small raster: 20x12 lines, 2 clk/pixel, 480 clk/frame.
  // hSync low h 0..2, visible h 5..14, v 3..8, vSync low v 0..1.
  vga_sync_gen #(
    .CLK_DIV(2), .H_TOTAL(20), .H_SYNC(3),
    .H_VIS_START(5), .H_VIS(10), .V_TOTAL(12),
    .V_SYNC(2), .V_VIS_START(3), .V_VIS(6)
  ) dut_b (
    .clk(clk), .reset(reset),
    .hCount(h_b), .vCount(v_b),
    .hSync(hs_b), .vSync(vs_b),
    .bright(br_b), .pix_en(pe_b),
    .frame_start(fs_b)
  );

  vga_sync_gen #(.CLK_DIV(1)) dut_c (
    .clk(clk), .reset(reset),
    .hCount(h_c), .vCount(v_c),
    .hSync(hs_c), .vSync(vs_c),
    .bright(br_c), .pix_en(pe_c),
    .frame_start(fs_c)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int n_hs, n_pe, n_br, n_vs, n_fs, bad;
  int rise_h, fall_h, hs95, hs96, vs_max, found;
  logic pb;
  logic [9:0] ph, pv;

  initial begin
    reset = 1'b1;
    tick(3);
    chk("rst_h", h_a, 0);
    chk("rst_v", v_a, 0);
    chk("rst_hs", hs_a, 0);
    chk("rst_vs", vs_a, 0);
    chk("rst_br", br_a, 0);
    chk("rst_pe", pe_a, 0);
    chk("rst_fs", fs_a, 0);
    chk("rst_pe_div1", pe_c, 1);
    reset = 1'b0;

    tick(3);
    chk("pe_clk4", pe_a, 1);
    chk("h_before_edge4", h_a, 0);
    chk("div1_h3", h_c, 3);
    tick(1);
    chk("h_edge4", h_a, 1);
    chk("pe_after_edge4", pe_a, 0);
    chk("div1_h4", h_c, 4);

    // Edge 3200 ends line 0 of the default build.
    tick(3196);
    chk("line0_wrap_h", h_a, 0);
    chk("line0_wrap_v", v_a, 1);

    n_hs = 0; n_pe = 0; n_br = 0;
    hs95 = -1; hs96 = -1;
    for (int i = 0; i < 3200; i++) begin
      if (!hs_a) n_hs++;
      if (pe_a) n_pe++;
      if (br_a) n_br++;
      if (h_a == 10'd95) hs95 = int'(hs_a);
      if (h_a == 10'd96) hs96 = int'(hs_a);
      tick(1);
    end
    chk("line_period_h", h_a, 0);
    chk("line_period_v", v_a, 2);
    chk("hsync_low_clk", n_hs, 384);
    chk("pix_per_line", n_pe, 800);
    chk("blank_line_br", n_br, 0);
    chk("hsync_at_95", hs95, 0);
    chk("hsync_at_96", hs96, 1);

    found = 0;
    for (int i = 0; i < 1000 && found == 0; i++) begin
      tick(1);
      if (fs_b) found = 1;
    end
    chk("b_fs_seen", found, 1);
    chk("b_fs_h", h_b, 0);
    chk("b_fs_v", v_b, 0);
    chk("b_fs_pe", pe_b, 0);

    n_fs = 0; n_br = 0; n_vs = 0; n_hs = 0; bad = 0;
    rise_h = -1; fall_h = -1; vs_max = -1;
    pb = br_b; ph = h_b; pv = v_b;
    for (int i = 1; i <= 480; i++) begin
      tick(1);
      if (fs_b) n_fs++;
      if (br_b) n_br++;
      if (!hs_b) n_hs++;
      if (!vs_b) begin
        n_vs++;
        if (int'(v_b) > vs_max) vs_max = int'(v_b);
      end
      if (br_b && (v_b < 10'd3 || v_b >= 10'd9)) bad++;
      if (ph == 10'd19 && h_b == 10'd0 &&
          v_b != ((pv == 10'd11) ? 10'd0 : pv + 10'd1))
        bad++;
      if (br_b && !pb && rise_h < 0) rise_h = int'(h_b);
      if (!br_b && pb && fall_h < 0) fall_h = int'(h_b);
      pb = br_b; ph = h_b; pv = v_b;
    end
    chk("b_frame_fs", fs_b, 1);
    chk("b_frame_h", h_b, 0);
    chk("b_frame_v", v_b, 0);
    chk("b_fs_count", n_fs, 1);
    chk("b_bright_clk", n_br, 120);
    chk("b_vsync_low_clk", n_vs, 80);
    chk("b_vsync_max_v", vs_max, 1);
    chk("b_hsync_low_clk", n_hs, 72);
    chk("b_rise_h", rise_h, 5);
    chk("b_fall_h", fall_h, 15);
    chk("b_vis_and_wrap", bad, 0);
    tick(1);
    chk("b_fs_1clk", fs_b, 0);

    found = 0;
    for (int i = 0; i < 40000 && found == 0; i++) begin
      tick(1);
      if (v_c == 10'd40 && h_c == 10'd0) found = 1;
    end
    chk("c_line40_seen", found, 1);
    n_pe = 0; bad = 0; rise_h = -1; fall_h = -1;
    pb = br_c; ph = h_c;
    for (int i = 0; i < 800; i++) begin
      tick(1);
      if (pe_c) n_pe++;
      if (h_c != ((ph == 10'd799) ? 10'd0 : ph + 10'd1))
        bad++;
      if (br_c && !pb && rise_h < 0) rise_h = int'(h_c);
      if (!br_c && pb && fall_h < 0) fall_h = int'(h_c);
      pb = br_c; ph = h_c;
    end
    chk("c_pe_always", n_pe, 800);
    chk("c_h_step", bad, 0);
    chk("c_line_h", h_c, 0);
    chk("c_line_v", v_c, 41);
    chk("c_rise_h", rise_h, 144);
    chk("c_fall_h", fall_h, 784);

    found = 0;
    for (int i = 0; i < 1000 && found == 0; i++) begin
      tick(1);
      if (v_b == 10'd5 && h_b == 10'd10) found = 1;
    end
    chk("b_mid_seen", found, 1);
    chk("b_mid_br", br_b, 1);
    reset = 1'b1;
    tick(1);
    chk("mid_rst_h", h_b, 0);
    chk("mid_rst_v", v_b, 0);
    chk("mid_rst_br", br_b, 0);
    chk("mid_rst_fs", fs_b, 0);
    chk("mid_rst_pe", pe_b, 0);
    chk("mid_rst_c_fs", fs_c, 0);
    reset = 1'b0;
    tick(1);
    chk("mid_rel_pe", pe_b, 1);
    chk("mid_rel_h0", h_b, 0);
    chk("mid_rel_fs", fs_b, 0);
    tick(1);
    chk("mid_rel_h1", h_b, 1);
    chk("mid_rel_v", v_b, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
